// File: rtl/mp_ctrl_pkg.sv
// Shared encodings for the microprocessor execution controller.
// States, rate selects and jump-to-self opcode fields.
package mp_ctrl_pkg;

    localparam logic [1:0] ST_HALT  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_STEP  = 2'b10;
    localparam logic [1:0] ST_BREAK = 2'b11;

    localparam logic [1:0] RATE_1 = 2'b00;
    localparam logic [1:0] RATE_2 = 2'b01;
    localparam logic [1:0] RATE_4 = 2'b10;

    localparam logic [1:0] OP_JUMP       = 2'b11;
    localparam logic [1:0] JUMP_SELF_IMM = 2'b11;

    function automatic logic is_jump_self(
        input logic [1:0] op,
        input logic [1:0] imm
    );
        return (op == OP_JUMP) && (imm == JUMP_SELF_IMM);
    endfunction

endpackage

// File: rtl/execution_controller_if.sv
// Core-side bundle: presented PC/instruction and the retire enable.
// master = core, slave = execution controller.
interface execution_controller_if;

    logic [7:0] pc;
    logic [7:0] instruction;
    logic       cpu_ce;

    modport master (
        output pc,
        output instruction,
        input  cpu_ce
    );

    modport slave (
        input  pc,
        input  instruction,
        output cpu_ce
    );

endinterface

// File: rtl/execution_controller_tick_gen.sv
// Free-running prescaler plus 2-bit rate divider.
// o_rate_tick is a one-cycle pulse at the selected instruction rate.
module tick_gen
    import mp_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 25000000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_rate_sel,
    output logic       o_rate_tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] r_presc;
    logic [1:0]    r_rate_cnt;
    logic          w_base_tick;
    logic          w_rate_hit;

    assign w_base_tick = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_presc    <= '0;
            r_rate_cnt <= '0;
        end else if (w_base_tick) begin
            r_presc    <= '0;
            r_rate_cnt <= r_rate_cnt + 2'd1;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_comb begin
        w_rate_hit = 1'b0;
        if (i_rate_sel == RATE_1)
            w_rate_hit = 1'b1;
        else if (i_rate_sel == RATE_2)
            w_rate_hit = r_rate_cnt[0];
        else
            w_rate_hit = &r_rate_cnt;
    end

    assign o_rate_tick = w_base_tick & w_rate_hit;

endmodule

// File: rtl/execution_controller.sv
// Run/halt/step sequencer producing the core's retire enable (cpu_ce),
// with one PC breakpoint, jump-to-self auto-halt and a retired counter.
module execution_controller
    import mp_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int CNT_W    = 16
) (
    input  logic                 oscillator,
    input  logic                 reset_n,
    input  logic                 run_btn,
    input  logic                 step_btn,
    input  logic                 halt_btn,
    input  logic [1:0]           rate_sel,
    input  logic                 bp_enable,
    input  logic [7:0]           bp_addr,
    execution_controller_if.slave core,
    output logic [1:0]           state,
    output logic                 halted,
    output logic                 bp_hit,
    output logic [CNT_W-1:0]     retired_count
);

    logic [1:0]       r_state;
    logic             r_cpu_ce;
    logic             r_bp_skip;
    logic [CNT_W-1:0] r_count;
    logic             r_run_prev;
    logic             r_step_prev;
    logic             r_halt_prev;

    logic w_run_edge;
    logic w_step_edge;
    logic w_halt_edge;
    logic w_rate_tick;
    logic w_bp_match;
    logic w_jself;
    logic w_run_go;
    logic w_issue;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk       (oscillator),
        .i_rst_n     (reset_n),
        .i_rate_sel  (rate_sel),
        .o_rate_tick (w_rate_tick)
    );

    assign w_run_edge  = run_btn  & ~r_run_prev;
    assign w_step_edge = step_btn & ~r_step_prev;
    assign w_halt_edge = halt_btn & ~r_halt_prev;

    assign w_bp_match = bp_enable & (core.pc == bp_addr) & ~r_bp_skip;
    assign w_jself    = is_jump_self(core.instruction[7:6],
                                     core.instruction[1:0]);

    // A RUN tick retires only when no halt, breakpoint or self-jump wins
    assign w_run_go = (r_state == ST_RUN) & ~w_halt_edge & w_rate_tick;
    assign w_issue  = (r_state == ST_STEP)
                    | (w_run_go & ~w_bp_match & ~w_jself);

    always_ff @(posedge oscillator) begin
        if (!reset_n) begin
            r_state     <= ST_HALT;
            r_cpu_ce    <= 1'b0;
            r_bp_skip   <= 1'b0;
            r_count     <= '0;
            r_run_prev  <= 1'b0;
            r_step_prev <= 1'b0;
            r_halt_prev <= 1'b0;
        end else begin
            r_run_prev  <= run_btn;
            r_step_prev <= step_btn;
            r_halt_prev <= halt_btn;
            r_cpu_ce    <= w_issue;

            if (w_issue) begin
                r_bp_skip <= 1'b0;
                if (r_count != {CNT_W{1'b1}})
                    r_count <= r_count + CNT_W'(1);
            end

            case (r_state)
                ST_HALT: begin
                    if (!w_halt_edge) begin
                        if (w_step_edge)
                            r_state <= ST_STEP;
                        else if (w_run_edge)
                            r_state <= ST_RUN;
                    end
                end
                ST_STEP: r_state <= ST_HALT;
                ST_RUN: begin
                    if (w_halt_edge)
                        r_state <= ST_HALT;
                    else if (w_rate_tick && w_bp_match)
                        r_state <= ST_BREAK;
                    else if (w_rate_tick && w_jself)
                        r_state <= ST_HALT;
                end
                ST_BREAK: begin
                    if (w_halt_edge) begin
                        r_state <= ST_HALT;
                    end else if (w_step_edge) begin
                        r_state   <= ST_STEP;
                        r_bp_skip <= 1'b1;
                    end else if (w_run_edge) begin
                        r_state   <= ST_RUN;
                        r_bp_skip <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign core.cpu_ce   = r_cpu_ce;
    assign state         = r_state;
    assign halted        = (r_state == ST_HALT) | (r_state == ST_BREAK);
    assign bp_hit        = (r_state == ST_BREAK);
    assign retired_count = r_count;

endmodule

// File: tb/tb_execution_controller.sv
// Directed bench for execution_controller with TICK_DIV=4, CNT_W=4.
// Outputs sampled 1 time unit after each rising edge.
module tb_execution_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run_btn, step_btn, halt_btn;
    logic [1:0] rate_sel;
    logic       bp_enable;
    logic [7:0] bp_addr;
    logic [1:0] state;
    logic       halted, bp_hit;
    logic [3:0] retired_count;

    int n_pass = 0;
    int n_total = 0;
    int n;
    logic saw;

    execution_controller_if core_if ();

    execution_controller #(
        .TICK_DIV (4),
        .CNT_W    (4)
    ) dut (
        .oscillator    (clk),
        .reset_n       (reset_n),
        .run_btn       (run_btn),
        .step_btn      (step_btn),
        .halt_btn      (halt_btn),
        .rate_sel      (rate_sel),
        .bp_enable     (bp_enable),
        .bp_addr       (bp_addr),
        .core          (core_if.slave),
        .state         (state),
        .halted        (halted),
        .bp_hit        (bp_hit),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ce(input int lim, output int cnt);
        cnt = 0;
        do begin
            cyc();
            cnt++;
        end while (!core_if.cpu_ce && cnt < lim);
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim,
                              output logic seen_ce);
        int k;
        k = 0;
        seen_ce = 1'b0;
        do begin
            cyc();
            if (core_if.cpu_ce) seen_ce = 1'b1;
            k++;
        end while (state != s && k < lim);
    endtask

    initial begin
        reset_n = 1'b0;
        run_btn = 1'b0;
        step_btn = 1'b0;
        halt_btn = 1'b0;
        rate_sel = 2'b01;
        bp_enable = 1'b0;
        bp_addr = 8'h00;
        core_if.pc = 8'h00;
        core_if.instruction = 8'h00;

        // reset
        cyc();
        cyc();
        chk("rst state", 32'(state), 32'h0);
        chk("rst halted", 32'(halted), 32'h1);
        chk("rst bp_hit", 32'(bp_hit), 32'h0);
        chk("rst cpu_ce", 32'(core_if.cpu_ce), 32'h0);
        chk("rst count", 32'(retired_count), 32'h0);
        reset_n = 1'b1;

        // single step
        step_btn = 1'b1;
        cyc();
        step_btn = 1'b0;
        chk("step state", 32'(state), 32'h2);
        chk("step no early ce", 32'(core_if.cpu_ce), 32'h0);
        cyc();
        chk("step ce", 32'(core_if.cpu_ce), 32'h1);
        chk("step back halt", 32'(state), 32'h0);
        chk("step count", 32'(retired_count), 32'h1);
        cyc();
        chk("step one pulse", 32'(core_if.cpu_ce), 32'h0);

        // run at every 2nd tick: period 8 cycles
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        chk("run state", 32'(state), 32'h1);
        chk("run halted", 32'(halted), 32'h0);
        wait_ce(40, n);
        chk("run first ce", 32'(core_if.cpu_ce), 32'h1);
        cyc();
        chk("run ce width", 32'(core_if.cpu_ce), 32'h0);
        wait_ce(40, n);
        chk("run second ce", 32'(core_if.cpu_ce), 32'h1);
        chk("run period", 32'(n + 1), 32'd8);
        chk("run count", 32'(retired_count), 32'h3);

        // jump-to-self halts without retiring
        core_if.instruction = 8'hC3;
        wait_state(2'b00, 40, saw);
        chk("jself state", 32'(state), 32'h0);
        chk("jself no ce", 32'(saw), 32'h0);
        chk("jself count", 32'(retired_count), 32'h3);
        core_if.instruction = 8'h00;

        // breakpoint
        bp_enable = 1'b1;
        bp_addr = 8'h05;
        core_if.pc = 8'h05;
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        chk("bp run", 32'(state), 32'h1);
        wait_state(2'b11, 40, saw);
        chk("bp state", 32'(state), 32'h3);
        chk("bp_hit", 32'(bp_hit), 32'h1);
        chk("bp halted", 32'(halted), 32'h1);
        chk("bp no ce", 32'(saw), 32'h0);
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        chk("bp resume", 32'(state), 32'h1);
        wait_ce(40, n);
        chk("bp skip ce", 32'(core_if.cpu_ce), 32'h1);
        core_if.pc = 8'h06;
        wait_ce(40, n);
        chk("bp next ce", 32'(core_if.cpu_ce), 32'h1);
        chk("bp still run", 32'(state), 32'h1);
        chk("bp count", 32'(retired_count), 32'h5);

        // halt beats run when simultaneous
        halt_btn = 1'b1;
        run_btn = 1'b1;
        cyc();
        halt_btn = 1'b0;
        run_btn = 1'b0;
        chk("prio halt", 32'(state), 32'h0);
        chk("prio no ce", 32'(core_if.cpu_ce), 32'h0);

        // saturation
        for (int i = 0; i < 20; i++) begin
            step_btn = 1'b1;
            cyc();
            step_btn = 1'b0;
            cyc();
            cyc();
        end
        chk("sat count", 32'(retired_count), 32'hF);
        chk("sat state", 32'(state), 32'h0);

        // reset while running
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        cyc();
        reset_n = 1'b0;
        cyc();
        chk("mid rst state", 32'(state), 32'h0);
        chk("mid rst count", 32'(retired_count), 32'h0);
        chk("mid rst ce", 32'(core_if.cpu_ce), 32'h0);
        reset_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
